// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array edge blocks.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } feeder_state_e;

  localparam int CNT_W_DEFAULT = 16;

  // LSB of lane `lane` on a flat ROWS*WIDTH bus (lane 0 in the low bits).
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_row_feeder_if.sv
// Column-vector input handshake and skewed west-edge outputs of the row feeder.
interface systolic_row_feeder_if #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4
);
  import systolic_pkg::*;

  // Handshake: a beat transfers in any cycle where in_valid_i && in_ready_o;
  // in_last_i and in_data_i are only meaningful in that cycle. in_ready_o
  // depends on feeder state only, never on in_valid_i.
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic                    in_last_i;
  logic [ROWS*WIDTH-1:0]   in_data_i;
  logic [ROWS*WIDTH-1:0]   west_o;
  logic [ROWS-1:0]         west_valid_o;

  modport master (
    output in_valid_i, in_last_i, in_data_i,
    input  in_ready_o, west_o, west_valid_o
  );

  modport slave (
    input  in_valid_i, in_last_i, in_data_i,
    output in_ready_o, west_o, west_valid_o
  );

endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth {valid, data} shift register with synchronous active-high reset.
module skew_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][WIDTH-1:0] r_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid[0] <= valid_i;
      r_data[0]  <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign valid_o = r_valid[DEPTH-1];
  assign data_o  = r_data[DEPTH-1];

endmodule

// File: rtl/systolic_row_feeder.sv
// Skews column vectors onto the array west edge (lane r delayed r+1 cycles).
// Optional feature macro: ROW_FEEDER_BUBBLE_CNT_EN adds bubble_cnt_o.
module systolic_row_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  systolic_row_feeder_if.slave  bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      beat_cnt_o,
`ifdef ROW_FEEDER_BUBBLE_CNT_EN
  output logic [CNT_W-1:0]      bubble_cnt_o,
`endif
  output feeder_state_e         state_o
);

  localparam int DRN_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  feeder_state_e    r_state;
  feeder_state_e    w_state_nxt;
  logic [DRN_W-1:0] r_drain_cnt;
  logic [DRN_W-1:0] w_drain_nxt;
  logic             w_done;
  logic             w_ready;
  logic             w_accept;
  logic [CNT_W-1:0] r_beat_cnt;

  assign w_ready  = (r_state != ST_DRAIN);
  assign w_accept = bus.in_valid_i && w_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (bus.in_last_i) begin
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = DRN_W'(ROWS - 1);
          end else begin
            w_state_nxt = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (w_accept && bus.in_last_i) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = DRN_W'(ROWS - 1);
        end
      end
      ST_DRAIN: begin
        // Count reaches zero exactly when the last lane shows the final element.
        if (r_drain_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_drain_nxt = r_drain_cnt - DRN_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      if (r_state == ST_IDLE) begin
        r_beat_cnt <= CNT_W'(1);
      end else if (r_beat_cnt != '1) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

`ifdef ROW_FEEDER_BUBBLE_CNT_EN
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bubble_cnt <= '0;
    end else if (w_accept && (r_state == ST_IDLE)) begin
      r_bubble_cnt <= '0;
    end else if ((r_state == ST_STREAM) && !w_accept && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign bubble_cnt_o = r_bubble_cnt;
`endif

  // Non-accepted cycles inject zero data so bubbles reach the PEs as zero diagonals.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [WIDTH-1:0] w_lane_in;

    assign w_lane_in = w_accept ? bus.in_data_i[lane_lsb(r, WIDTH) +: WIDTH] : '0;

    skew_delay_line #(
      .WIDTH (WIDTH),
      .DEPTH (r + 1)
    ) u_line (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (w_accept),
      .data_i  (w_lane_in),
      .valid_o (bus.west_valid_o[r]),
      .data_o  (bus.west_o[lane_lsb(r, WIDTH) +: WIDTH])
    );
  end

  assign bus.in_ready_o = w_ready;
  assign busy_o         = (r_state != ST_IDLE);
  assign done_o         = w_done;
  assign beat_cnt_o     = r_beat_cnt;
  assign state_o        = r_state;

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Directed bench for systolic_row_feeder (WIDTH=8, ROWS=4).
module tb_systolic_row_feeder;
  import systolic_pkg::*;

  localparam int WIDTH = 8;
  localparam int ROWS  = 4;
  localparam int CNT_W = 16;
  localparam int BUS_W = ROWS * WIDTH;
  localparam int MAXC  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_row_feeder_if #(.WIDTH(WIDTH), .ROWS(ROWS)) bus ();

  logic             busy;
  logic             done;
  logic [CNT_W-1:0] beat_cnt;
  feeder_state_e    state;
`ifdef ROW_FEEDER_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt;
`endif

  systolic_row_feeder #(.WIDTH(WIDTH), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .beat_cnt_o   (beat_cnt),
`ifdef ROW_FEEDER_BUBBLE_CNT_EN
    .bubble_cnt_o (bubble_cnt),
`endif
    .state_o      (state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end want end");
    $fatal(1);
  end

  // ---------------- stimulus tables / observations ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  logic             stim_v   [MAXC];
  logic             stim_l   [MAXC];
  logic             stim_r   [MAXC];
  logic             stim_acc [MAXC];
  logic [BUS_W-1:0] stim_d   [MAXC];

  logic [BUS_W-1:0] obs_w    [MAXC];
  logic [ROWS-1:0]  obs_wv   [MAXC];
  logic             obs_rdy  [MAXC];
  logic             obs_busy [MAXC];
  logic             obs_done [MAXC];
  logic [CNT_W-1:0] obs_cnt  [MAXC];
  feeder_state_e    obs_st   [MAXC];
`ifdef ROW_FEEDER_BUBBLE_CNT_EN
  logic [CNT_W-1:0] obs_bub  [MAXC];
`endif

  logic [WIDTH-1:0] exp_q[$];

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin
      stim_v[k]   = 1'b0;
      stim_l[k]   = 1'b0;
      stim_r[k]   = 1'b0;
      stim_acc[k] = 1'b0;
      stim_d[k]   = '0;
    end
  endtask

  // Each step: sample outputs of cycle k at the falling edge, then drive cycle k inputs.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs_w[k]    = bus.west_o;
      obs_wv[k]   = bus.west_valid_o;
      obs_rdy[k]  = bus.in_ready_o;
      obs_busy[k] = busy;
      obs_done[k] = done;
      obs_cnt[k]  = beat_cnt;
      obs_st[k]   = state;
`ifdef ROW_FEEDER_BUBBLE_CNT_EN
      obs_bub[k]  = bubble_cnt;
`endif
      rst            = stim_r[k];
      bus.in_valid_i = stim_v[k];
      bus.in_last_i  = stim_l[k];
      bus.in_data_i  = stim_d[k];
    end
  endtask

  // Reference: lane r in cycle k shows whatever beat was accepted in cycle k-1-r.
  function automatic logic [WIDTH-1:0] exp_lane(input int k, input int r);
    int s = k - 1 - r;
    logic [BUS_W-1:0] d;
    if (s < 0 || s >= MAXC || !stim_acc[s]) return '0;
    d = stim_d[s];
    return d[r*WIDTH +: WIDTH];
  endfunction

  function automatic logic exp_lane_v(input int k, input int r);
    int s = k - 1 - r;
    if (s < 0 || s >= MAXC) return 1'b0;
    return stim_acc[s];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_stim();
    stim_r[0] = 1'b1; stim_r[1] = 1'b1; stim_r[2] = 1'b1;
    run(6);
    for (int k = 0; k < 6; k++) begin
      total_cnt++;
      if (obs_w[k] !== '0 || obs_wv[k] !== '0 || obs_rdy[k] !== 1'b1 || obs_busy[k] !== 1'b0 ||
          obs_done[k] !== 1'b0 || obs_cnt[k] !== '0 || obs_st[k] !== ST_IDLE)
        $display("FAIL reset k=%0d got west=%h wv=%b rdy=%b busy=%b done=%b cnt=%0d st=%0d want 0/0/1/0/0/0/IDLE",
                 k, obs_w[k], obs_wv[k], obs_rdy[k], obs_busy[k], obs_done[k], obs_cnt[k], obs_st[k]);
      else pass_cnt++;
`ifdef ROW_FEEDER_BUBBLE_CNT_EN
      total_cnt++;
      if (obs_bub[k] !== '0) $display("FAIL reset_bubble k=%0d got %0d want 0", k, obs_bub[k]);
      else pass_cnt++;
`endif
    end
  endtask

  task automatic test_skew();
    clear_stim();
    stim_v[0] = 1; stim_d[0] = 32'h04030201; stim_acc[0] = 1;
    stim_v[1] = 1; stim_d[1] = 32'h08070605; stim_acc[1] = 1;
    stim_v[2] = 1; stim_d[2] = 32'h0C0B0A09; stim_acc[2] = 1; stim_l[2] = 1;
    run(9);
    for (int k = 1; k < 9; k++) begin
      for (int r = 0; r < ROWS; r++) begin
        total_cnt++;
        if (obs_w[k][r*WIDTH +: WIDTH] !== exp_lane(k, r) || obs_wv[k][r] !== exp_lane_v(k, r))
          $display("FAIL skew_lane k=%0d r=%0d got %h/%b want %h/%b", k, r,
                   obs_w[k][r*WIDTH +: WIDTH], obs_wv[k][r], exp_lane(k, r), exp_lane_v(k, r));
        else pass_cnt++;
      end
    end
    exp_q.push_back(8'd4); exp_q.push_back(8'd8); exp_q.push_back(8'd12);
    for (int k = 4; k <= 6; k++) begin
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      total_cnt++;
      if (obs_w[k][3*WIDTH +: WIDTH] !== e || obs_wv[k][3] !== 1'b1)
        $display("FAIL skew_lane3 k=%0d got %0d/%b want %0d/1", k, obs_w[k][3*WIDTH +: WIDTH], obs_wv[k][3], e);
      else pass_cnt++;
    end
    for (int k = 0; k < 9; k++) begin
      total_cnt++;
      if (obs_done[k] !== (k == 6)) $display("FAIL skew_done k=%0d got %b want %b", k, obs_done[k], (k == 6));
      else pass_cnt++;
      total_cnt++;
      if (obs_rdy[k] !== !(k >= 3 && k <= 6))
        $display("FAIL skew_ready k=%0d got %b want %b", k, obs_rdy[k], !(k >= 3 && k <= 6));
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_cnt[7] !== 16'd3 || obs_busy[7] !== 1'b0 || obs_st[4] !== ST_DRAIN)
      $display("FAIL skew_status got cnt=%0d busy=%b st4=%0d want 3/0/DRAIN", obs_cnt[7], obs_busy[7], obs_st[4]);
    else pass_cnt++;
  endtask

  task automatic test_bubble();
    clear_stim();
    stim_v[0] = 1; stim_d[0] = 32'h01010101; stim_acc[0] = 1;
    stim_v[1] = 0; stim_d[1] = 32'hDEADBEEF; stim_l[1] = 1;
    stim_v[2] = 1; stim_d[2] = 32'h02020202; stim_acc[2] = 1; stim_l[2] = 1;
    run(9);
    for (int k = 1; k < 9; k++) begin
      for (int r = 0; r < ROWS; r++) begin
        total_cnt++;
        if (obs_w[k][r*WIDTH +: WIDTH] !== exp_lane(k, r) || obs_wv[k][r] !== exp_lane_v(k, r))
          $display("FAIL bubble_lane k=%0d r=%0d got %h/%b want %h/%b", k, r,
                   obs_w[k][r*WIDTH +: WIDTH], obs_wv[k][r], exp_lane(k, r), exp_lane_v(k, r));
        else pass_cnt++;
      end
      total_cnt++;
      if (obs_done[k] !== (k == 6)) $display("FAIL bubble_done k=%0d got %b want %b", k, obs_done[k], (k == 6));
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_st[2] !== ST_STREAM) $display("FAIL bubble_last_ignored got st=%0d want STREAM", obs_st[2]);
    else pass_cnt++;
    total_cnt++;
    if (obs_cnt[7] !== 16'd2) $display("FAIL bubble_beat_cnt got %0d want 2", obs_cnt[7]);
    else pass_cnt++;
`ifdef ROW_FEEDER_BUBBLE_CNT_EN
    total_cnt++;
    if (obs_bub[7] !== 16'd1) $display("FAIL bubble_cnt got %0d want 1", obs_bub[7]);
    else pass_cnt++;
`endif
  endtask

  task automatic test_single_beat();
    clear_stim();
    stim_v[0] = 1; stim_l[0] = 1; stim_d[0] = 32'h00FF7F80; stim_acc[0] = 1;
    run(7);
    for (int k = 1; k < 7; k++) begin
      for (int r = 0; r < ROWS; r++) begin
        total_cnt++;
        if (obs_w[k][r*WIDTH +: WIDTH] !== exp_lane(k, r) || obs_wv[k][r] !== exp_lane_v(k, r))
          $display("FAIL single_lane k=%0d r=%0d got %h/%b want %h/%b", k, r,
                   obs_w[k][r*WIDTH +: WIDTH], obs_wv[k][r], exp_lane(k, r), exp_lane_v(k, r));
        else pass_cnt++;
      end
      total_cnt++;
      if (obs_done[k] !== (k == 4)) $display("FAIL single_done k=%0d got %b want %b", k, obs_done[k], (k == 4));
      else pass_cnt++;
      total_cnt++;
      if (obs_rdy[k] !== (k >= 5)) $display("FAIL single_ready k=%0d got %b want %b", k, obs_rdy[k], (k >= 5));
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_st[1] !== ST_DRAIN || obs_cnt[5] !== 16'd1)
      $display("FAIL single_status got st1=%0d cnt=%0d want DRAIN/1", obs_st[1], obs_cnt[5]);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    clear_stim();
    stim_v[0] = 1; stim_d[0] = 32'h04030201; stim_acc[0] = 1;
    stim_v[1] = 1; stim_d[1] = 32'h08070605; stim_acc[1] = 1; stim_l[1] = 1;
    for (int k = 2; k <= 6; k++) begin
      stim_v[k] = 1; stim_l[k] = 1; stim_d[k] = 32'h44332211;
    end
    stim_acc[6] = 1;
    run(12);
    for (int k = 1; k < 12; k++) begin
      for (int r = 0; r < ROWS; r++) begin
        total_cnt++;
        if (obs_w[k][r*WIDTH +: WIDTH] !== exp_lane(k, r) || obs_wv[k][r] !== exp_lane_v(k, r))
          $display("FAIL bp_lane k=%0d r=%0d got %h/%b want %h/%b", k, r,
                   obs_w[k][r*WIDTH +: WIDTH], obs_wv[k][r], exp_lane(k, r), exp_lane_v(k, r));
        else pass_cnt++;
      end
      total_cnt++;
      if (obs_done[k] !== (k == 5 || k == 10))
        $display("FAIL bp_done k=%0d got %b want %b", k, obs_done[k], (k == 5 || k == 10));
      else pass_cnt++;
      total_cnt++;
      if (obs_rdy[k] !== !((k >= 2 && k <= 5) || (k >= 7 && k <= 10)))
        $display("FAIL bp_ready k=%0d got %b want %b", k, obs_rdy[k], !((k >= 2 && k <= 5) || (k >= 7 && k <= 10)));
      else pass_cnt++;
    end
    total_cnt++;
    if (obs_cnt[6] !== 16'd2 || obs_cnt[7] !== 16'd1)
      $display("FAIL bp_beat_cnt got %0d,%0d want 2,1", obs_cnt[6], obs_cnt[7]);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    clear_stim();
    stim_v[0] = 1; stim_d[0] = 32'h0D0C0B0A; stim_acc[0] = 1;
    stim_v[1] = 1; stim_d[1] = 32'h11100F0E; stim_acc[1] = 1; stim_l[1] = 1;
    stim_r[3] = 1;
    run(9);
    total_cnt++;
    if (obs_st[3] !== ST_DRAIN) $display("FAIL midrst_pre got st=%0d want DRAIN", obs_st[3]);
    else pass_cnt++;
    for (int k = 4; k < 9; k++) begin
      total_cnt++;
      if (obs_w[k] !== '0 || obs_wv[k] !== '0 || obs_rdy[k] !== 1'b1 || obs_busy[k] !== 1'b0 ||
          obs_cnt[k] !== '0 || obs_st[k] !== ST_IDLE)
        $display("FAIL midrst k=%0d got west=%h wv=%b rdy=%b busy=%b cnt=%0d st=%0d want 0/0/1/0/0/IDLE",
                 k, obs_w[k], obs_wv[k], obs_rdy[k], obs_busy[k], obs_cnt[k], obs_st[k]);
      else pass_cnt++;
    end
    for (int k = 0; k < 9; k++) begin
      total_cnt++;
      if (obs_done[k] !== 1'b0) $display("FAIL midrst_done k=%0d got %b want 0", k, obs_done[k]);
      else pass_cnt++;
    end
  endtask

  initial begin
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
    bus.in_data_i  = '0;
    test_reset();
    test_skew();
    test_bubble();
    test_single_beat();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
